// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with start/busy/done handshake,
// overflow saturation and a per-digit select output.
module bin2bcd_seq #(
    parameter int BIN_W = 12,
    parameter int DIG   = 4,
    parameter int SEL_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [BIN_W-1:0] i_bin,
    input  logic             i_start,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf,
    output logic [4*DIG-1:0] o_bcd,
    output logic [3:0]       o_dec
);
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p;
    endfunction

    localparam logic [31:0] LIMIT = pow10(DIG);
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t           r_state, w_next;
    logic [BIN_W-1:0] r_bin;
    logic [4*DIG-1:0] r_scr, w_adj, w_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_accept, w_last;
    logic [3:0]       w_dec;

    assign w_accept = (r_state == IDLE) && i_start;
    assign w_last   = r_cnt == CNT_W'(1);
    assign w_shift  = {w_adj[4*DIG-2:0], r_bin[BIN_W-1]};
    assign o_busy   = r_state == CONV;
    assign o_dec    = w_dec;

    always_comb begin
        w_adj = r_scr;
        for (int d = 0; d < DIG; d++)
            w_adj[4*d+:4] = (r_scr[4*d+:4] >= 4'd5) ? r_scr[4*d+:4] + 4'd3 : r_scr[4*d+:4];
    end

    always_comb begin
        w_dec = 4'h0;
        for (int d = 0; d < DIG; d++)
            if (i_sel == SEL_W'(d)) w_dec = o_bcd[4*d+:4];
    end

    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = CONV;
        else if (r_state == CONV && w_last) w_next = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bin  <= '0;
            r_scr  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            o_done <= 1'b0;
            o_ovf  <= 1'b0;
            o_bcd  <= '0;
        end else begin
            o_done <= 1'b0;
            if (w_accept) begin
                r_bin <= i_bin;
                r_scr <= '0;
                r_cnt <= CNT_W'(BIN_W);
                r_ovf <= 32'(i_bin) >= LIMIT;
            end else if (r_state == CONV) begin
                r_scr <= w_shift;
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt - CNT_W'(1);
                // Saturated results replace whatever the scratch register holds.
                if (w_last) begin
                    o_bcd  <= r_ovf ? {DIG{4'h9}} : w_shift;
                    o_ovf  <= r_ovf;
                    o_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed tests for bin2bcd_seq in the default (12-bit, 4-digit)
// configuration and a 7-bit, 2-digit configuration.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic        a_rst_n = 1'b0, a_start = 1'b0;
    logic [11:0] a_bin = '0;
    logic [1:0]  a_sel = '0;
    logic        a_busy, a_done, a_ovf;
    logic [15:0] a_bcd;
    logic [3:0]  a_dec;

    logic        b_rst_n = 1'b0, b_start = 1'b0;
    logic [6:0]  b_bin = '0;
    logic [1:0]  b_sel = '0;
    logic        b_busy, b_done, b_ovf;
    logic [7:0]  b_bcd;
    logic [3:0]  b_dec;

    always #5 clk = ~clk;

    bin2bcd_seq u_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_bin(a_bin), .i_start(a_start), .i_sel(a_sel),
        .o_busy(a_busy), .o_done(a_done), .o_ovf(a_ovf), .o_bcd(a_bcd), .o_dec(a_dec)
    );

    bin2bcd_seq #(.BIN_W(7), .DIG(2), .SEL_W(2)) u_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_bin(b_bin), .i_start(b_start), .i_sel(b_sel),
        .o_busy(b_busy), .o_done(b_done), .o_ovf(b_ovf), .o_bcd(b_bcd), .o_dec(b_dec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [11:0] v);
        a_bin = v;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic start_b(input logic [6:0] v);
        b_bin = v;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
    endtask

    task automatic wait_a(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (a_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_b(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (b_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int dones;
        a_rst_n = 1'b0;
        a_start = 1'b1;
        tick();
        tick();
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
        checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", a_done); end
        checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", a_ovf); end
        checks++; if (a_bcd !== 16'h0) begin failures++; $display("FAIL rst_bcd got=%h exp=0000", a_bcd); end
        checks++; if (a_dec !== 4'h0) begin failures++; $display("FAIL rst_dec got=%h exp=0", a_dec); end
        a_start = 1'b0;
        a_rst_n = 1'b1;
        tick();
        start_a(12'd1234);
        for (int n = 0; n < 4; n++) tick();
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", a_busy); end
        a_rst_n = 1'b0;
        tick();
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", a_busy); end
        checks++; if (a_bcd !== 16'h0) begin failures++; $display("FAIL abort_bcd got=%h exp=0000", a_bcd); end
        a_rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 16; n++) begin
            if (a_done) dones++;
            tick();
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    endtask

    task automatic test_latency();
        int busy_cnt, done_cnt, done_at;
        logic [3:0] exp_dec [4];
        exp_dec = '{4'd5, 4'd9, 4'd0, 4'd4};
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        start_a(12'd4095);
        for (int n = 0; n < 20; n++) begin
            if (a_busy) busy_cnt++;
            if (a_done) begin
                done_cnt++;
                done_at = n;
                checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL lat_busy_at_done got=%b exp=0", a_busy); end
                checks++; if (a_bcd !== 16'h4095) begin failures++; $display("FAIL lat_bcd got=%h exp=4095", a_bcd); end
                checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL lat_ovf got=%b exp=0", a_ovf); end
            end
            tick();
        end
        checks++; if (busy_cnt !== 12) begin failures++; $display("FAIL lat_busy_cycles got=%0d exp=12", busy_cnt); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL lat_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_at !== 12) begin failures++; $display("FAIL lat_done_edge got=%0d exp=12", done_at); end
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            #1;
            checks++; if (a_dec !== exp_dec[s]) begin failures++; $display("FAIL lat_dec sel=%0d got=%h exp=%h", s, a_dec, exp_dec[s]); end
        end
        a_sel = 2'd0;
    endtask

    task automatic test_sweep();
        bit ok;
        logic [7:0] e;
        b_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            e = {4'(i / 10), 4'(i % 10)};
            start_b(7'(i));
            wait_b(ok);
            checks++; if (!ok) begin failures++; $display("FAIL sweep_timeout i=%0d got=no_done exp=done", i); end
            checks++; if (b_bcd !== e) begin failures++; $display("FAIL sweep_bcd i=%0d got=%h exp=%h", i, b_bcd, e); end
            checks++; if (b_ovf !== 1'b0) begin failures++; $display("FAIL sweep_ovf i=%0d got=%b exp=0", i, b_ovf); end
            for (int s = 0; s < 4; s++) begin
                b_sel = 2'(s);
                #1;
                checks++;
                if (b_dec !== (s == 0 ? e[3:0] : s == 1 ? e[7:4] : 4'h0)) begin
                    failures++;
                    $display("FAIL sweep_dec i=%0d sel=%0d got=%h", i, s, b_dec);
                end
            end
            b_sel = 2'd0;
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [6:0] vals [3];
        logic [7:0] exp_bcd [3];
        logic       exp_ovf [3];
        vals = '{7'd100, 7'd127, 7'd42};
        exp_bcd = '{8'h99, 8'h99, 8'h42};
        exp_ovf = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            start_b(vals[k]);
            wait_b(ok);
            checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout v=%0d got=no_done exp=done", vals[k]); end
            checks++; if (b_bcd !== exp_bcd[k]) begin failures++; $display("FAIL ovf_bcd v=%0d got=%h exp=%h", vals[k], b_bcd, exp_bcd[k]); end
            checks++; if (b_ovf !== exp_ovf[k]) begin failures++; $display("FAIL ovf_flag v=%0d got=%b exp=%b", vals[k], b_ovf, exp_ovf[k]); end
        end
    endtask

    task automatic test_start_busy();
        int dones;
        logic [15:0] got;
        dones = 0;
        got = '0;
        start_a(12'd321);
        for (int n = 0; n < 30; n++) begin
            if (a_done) begin
                dones++;
                got = a_bcd;
            end
            a_bin = 12'd999;
            a_start = (n == 3 || n == 11);
            tick();
        end
        a_start = 1'b0;
        checks++; if (dones !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
        checks++; if (got !== 16'h0321) begin failures++; $display("FAIL busy_bcd got=%h exp=0321", got); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL busy_idle_after got=%b exp=0", a_busy); end
    endtask

    task automatic test_held();
        int times [$];
        a_bin = 12'd7;
        a_start = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (a_done) begin
                times.push_back(n);
                checks++; if (a_bcd !== 16'h0007) begin failures++; $display("FAIL held_bcd n=%0d got=%h exp=0007", n, a_bcd); end
            end
        end
        a_start = 1'b0;
        checks++; if (times.size() !== 3) begin failures++; $display("FAIL held_count got=%0d exp=3", times.size()); end
        if (times.size() > 0) begin
            checks++; if (times[0] !== 13) begin failures++; $display("FAIL held_first got=%0d exp=13", times[0]); end
        end
        for (int k = 1; k < times.size(); k++) begin
            checks++;
            if (times[k] - times[k-1] !== 13) begin
                failures++;
                $display("FAIL held_period got=%0d exp=13", times[k] - times[k-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_overflow();
        test_start_busy();
        test_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter that supersedes the combinational two-digit `bin2dec` decoder in the temperature-readout path. It converts a `BIN_W`-bit unsigned value into `DIG` packed BCD digits using iterative shift-and-add-3 (double-dabble), one input bit per clock. It has a start/busy/done handshake, saturates on overflow, and provides a per-digit select port for the 7-segment/digit-multiplexing logic.

## Interface
- `BIN_W`, default 12: width of the binary input; legal range 1..30.
- `DIG`, default 4: number of BCD output digits; legal range 1..9.
- `SEL_W`, default 2: width of `i_sel`; must satisfy 2^`SEL_W` ≥ `DIG`, minimum 1.
- `i_clk`  in  1  single clock; all state changes on rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset, sampled on rising edge of `i_clk`.
- `i_bin`  in  `BIN_W`  unsigned binary value; sampled only on the start-accept edge.
- `i_start`  in  1  conversion request; level-sampled.
- `i_sel`  in  `SEL_W`  digit select for `o_dec`; 0 = ones, 1 = tens, etc.
- `o_busy`  out  1  high while a conversion is in progress.
- `o_done`  out  1  one-cycle pulse; `o_bcd`/`o_ovf` updated in the same cycle.
- `o_ovf`  out  1  last result saturated (input ≥ 10^`DIG`).
- `o_bcd`  out  4·`DIG`  packed result; digit d at bits [4d+3:4d], digit 0 = ones.
- `o_dec`  out  4  selected digit of `o_bcd`.

## Operation
- States: IDLE, CONV.
- IDLE → CONV: on a rising edge with `i_start`=1 in IDLE.
  - Capture `i_bin` into the shift register.
  - Clear the BCD scratch register (4·`DIG` bits).
  - Load the bit counter with `BIN_W`.
  - Set the overflow flag to (`i_bin` ≥ 10^`DIG`). 10^`DIG` is computed at elaboration, 32-bit.
- CONV, each edge:
  - Add 3 to every scratch digit ≥ 5.
  - Shift {scratch, binary} left by one.
  - Decrement the counter.
- CONV → IDLE: on the edge that performs the final (`BIN_W`-th) shift.
  - Write the post-shift scratch into `o_bcd`, or all digits = 9 if the overflow flag is set.
  - Write the overflow flag to `o_ovf`.
  - Set `o_done`=1 for exactly one cycle.
- `o_bcd` and `o_ovf` hold their values until the next completion or reset. The scratch register is never exposed.
- `i_start` while in CONV: ignored; the in-flight conversion and the captured input are unaffected.
- `i_start` held high continuously: a new conversion is accepted on the first edge after return to IDLE.
- `o_dec` = `o_bcd`[4·`i_sel` +: 4], combinational from registered data. For `i_sel` ≥ `DIG`, `o_dec` = 4'h0.
- Digit-add logic never produces a digit > 9 for in-range inputs. For out-of-range inputs the scratch content is discarded by saturation.

## Timing
- Reset (`i_rst_n`=0 at an edge) gives state IDLE, `o_busy`=0, `o_done`=0, `o_ovf`=0, `o_bcd`=0, so `o_dec`=0. Reset overrides `i_start`.
- Reset mid-conversion: the conversion is aborted and no `o_done` is produced. The outputs take the values above.
- Let the start-accept edge be edge k.
  - `o_busy` is high after edges k through k+`BIN_W`−1, i.e. for `BIN_W` cycles.
  - `o_done` is high only after edge k+`BIN_W`; `o_busy` is 0 in that cycle.
  - Latency from accept edge to valid result: `BIN_W` edges.
- Earliest next accept is edge k+`BIN_W`+1, giving back-to-back throughput of one result per `BIN_W`+1 cycles.
- `o_dec` follows `i_sel` within the same cycle, with no registered delay.

## Test plan
- **Reset defaults and mid-conversion reset** (defaults): assert `i_rst_n`=0 for 2 cycles → all outputs 0. Start `i_bin`=1234, then drop `i_rst_n` after 5 cycles → `o_busy`=0, no `o_done`, `o_bcd`=0.
- **Latency, handshake and full scale** (defaults): `i_bin`=4095 with a 1-cycle `i_start` →
  - `o_busy` high for exactly 12 cycles;
  - `o_done` pulses once, 12 edges after accept;
  - `o_bcd`=16'h4095, `o_ovf`=0;
  - `i_sel`=0..3 gives `o_dec`=5,9,0,4.
- **Exhaustive sweep** (`BIN_W`=7, `DIG`=2): for i = 0..99, start then wait for `o_done` → `o_bcd`=={i/10, i%10} and `o_ovf`=0. Check `o_dec` for `i_sel`=0/1 against ones/tens; `i_sel`=2/3 → 0.
- **Overflow saturation** (`BIN_W`=7, `DIG`=2): `i_bin`=100 and 127 → `o_bcd`=8'h99, `o_ovf`=1. A following `i_bin`=42 → `o_bcd`=8'h42, `o_ovf`=0.
- **Start while busy** (defaults): start with 321, then pulse `i_start` with `i_bin`=999 at cycles 3 and 11 → a single `o_done` with `o_bcd`=16'h0321.
- **Held start** (defaults): hold `i_start`=1 with `i_bin`=7 → `o_done` pulses every 13 cycles, `o_bcd`=16'h0007 each time.
